// File: rtl/decode_queue_pkg.sv
// Shared decoded-uop definitions: field widths, one-hot instruction formats and the packed
// micro-op payload (308 bits at defaults) used by DecodeMux, decode_queue and dispatch.
package decode_queue_pkg;

    localparam int unsigned AddressWidth         = 64;
    localparam int unsigned InstCounterWidth     = 64;
    localparam int unsigned InstMinIdWidth       = 7;
    localparam int unsigned OpcodeSize           = 12;
    localparam int unsigned FuncUnitCodeSize     = 3;
    localparam int unsigned PidSize              = 20;
    localparam int unsigned TidSize              = 16;
    localparam int unsigned RegAccessPatternSize = 2;
    localparam int unsigned BodyWidth            = 84;
    localparam int unsigned InstFormatWidth      = 25;
    localparam int unsigned NumOperands          = 4;

    // One-hot instruction format codes.
    localparam logic [InstFormatWidth-1:0] FmtI = InstFormatWidth'(1) << 0;
    localparam logic [InstFormatWidth-1:0] FmtB = InstFormatWidth'(1) << 1;
    localparam logic [InstFormatWidth-1:0] FmtD = InstFormatWidth'(1) << 2;
    localparam logic [InstFormatWidth-1:0] FmtA = InstFormatWidth'(1) << 3;
    localparam logic [InstFormatWidth-1:0] FmtR = InstFormatWidth'(1) << 4;
    localparam logic [InstFormatWidth-1:0] FmtS = InstFormatWidth'(1) << 5;

    typedef struct packed {
        logic [InstFormatWidth-1:0]                       inst_format;
        logic [OpcodeSize-1:0]                            opcode;
        logic [AddressWidth-1:0]                          address;
        logic [FuncUnitCodeSize-1:0]                      func_unit;
        logic [InstCounterWidth-1:0]                      maj_id;
        logic [InstMinIdWidth-1:0]                        min_id;
        logic                                             is_64bit;
        logic [PidSize-1:0]                               pid;
        logic [TidSize-1:0]                               tid;
        logic [NumOperands-1:0][RegAccessPatternSize-1:0] op_rw;
        logic [NumOperands-1:0]                           op_is_reg;
        logic [BodyWidth-1:0]                             body;
    } uop_t;

    localparam int unsigned UopWidth = $bits(uop_t);

    // Field LSB offsets inside the packed payload, for consumers that slice the flat vector.
    localparam int unsigned UopBodyLsb     = 0;
    localparam int unsigned UopIsRegLsb    = UopBodyLsb + BodyWidth;
    localparam int unsigned UopRwLsb       = UopIsRegLsb + NumOperands;
    localparam int unsigned UopTidLsb      = UopRwLsb + NumOperands * RegAccessPatternSize;
    localparam int unsigned UopPidLsb      = UopTidLsb + TidSize;
    localparam int unsigned UopIs64Lsb     = UopPidLsb + PidSize;
    localparam int unsigned UopMinIdLsb    = UopIs64Lsb + 1;
    localparam int unsigned UopMajIdLsb    = UopMinIdLsb + InstMinIdWidth;
    localparam int unsigned UopFuncUnitLsb = UopMajIdLsb + InstCounterWidth;
    localparam int unsigned UopAddressLsb  = UopFuncUnitLsb + FuncUnitCodeSize;
    localparam int unsigned UopOpcodeLsb   = UopAddressLsb + AddressWidth;
    localparam int unsigned UopFormatLsb   = UopOpcodeLsb + OpcodeSize;

endpackage

// File: rtl/decode_queue_if.sv
// Decode-to-dispatch queue interface: enqueue side from DecodeMux, head side to dispatch.
// Optional perf counter signals exist only when DECODE_QUEUE_PERF_EN is defined.
interface decode_queue_if #(
    parameter int unsigned Depth = 8
);
    import decode_queue_pkg::*;

    localparam int unsigned CountW = $clog2(Depth) + 1;

    logic              flush;
    logic              enable;
    logic              stall;
    uop_t              enq_uop;
    logic              valid;
    logic              ready;
    uop_t              head_uop;
    logic [CountW-1:0] count;
    logic              overflow;
`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0]       enq_count;
    logic [31:0]       stall_cycles;

    modport slave (
        input  flush, enable, enq_uop, ready,
        output stall, valid, head_uop, count, overflow, enq_count, stall_cycles
    );
    modport master (
        output flush, enable, enq_uop, ready,
        input  stall, valid, head_uop, count, overflow, enq_count, stall_cycles
    );
`else
    modport slave (
        input  flush, enable, enq_uop, ready,
        output stall, valid, head_uop, count, overflow
    );
    modport master (
        output flush, enable, enq_uop, ready,
        input  stall, valid, head_uop, count, overflow
    );
`endif

endinterface

// File: rtl/decode_queue_storage.sv
// Payload register array for the decode queue: one synchronous write port, one asynchronous
// read port. The array is intentionally not reset; validity is tracked by the pointers.
module decode_queue_storage
    import decode_queue_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic            clock_i,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_idx,
    input  uop_t            wr_data,
    input  logic [IdxW-1:0] rd_idx,
    output uop_t            rd_data
);

    uop_t mem_q [Depth];

    // Write the accepted micro-op into its slot.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue between DecodeMux and dispatch. Stalls decode early enough to absorb
// the in-flight decode stages and presents the oldest micro-op with valid/ready.
// Optional: DECODE_QUEUE_PERF_EN adds saturating enqueue and stall-cycle counters.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned Depth         = 8,
    parameter int unsigned InFlightSlack = 3
) (
    input logic          clock_i,
    input logic          reset_i,
    decode_queue_if.slave dq
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] StallLevel = PtrW'(Depth - InFlightSlack);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] count, count_next;
    logic            stall_q, overflow_q, overflow_d;
    logic            full, valid, enq, deq;
    uop_t            head;

    // Pointers carry a wrap bit, so occupancy is their plain difference.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                   (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
    assign valid = (count != '0);
    assign deq   = valid & dq.ready & ~dq.flush;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq   = dq.enable & (~full | deq) & ~dq.flush;

    // Next pointers; flush empties the queue and wins over any enqueue/dequeue.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (dq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // Decode ignored the stall: the micro-op is lost.
            if (dq.enable && !enq) begin
                overflow_d = 1'b1;
            end
        end
        count_next = wr_ptr_d - rd_ptr_d;
    end

    // Pointer, stall and sticky overflow state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            stall_q    <= (count_next >= StallLevel);
            overflow_q <= overflow_d;
        end
    end

    decode_queue_storage #(
        .Depth (Depth)
    ) u_storage (
        .clock_i (clock_i),
        .wr_en   (enq),
        .wr_idx  (wr_ptr_q[IdxW-1:0]),
        .wr_data (dq.enq_uop),
        .rd_idx  (rd_ptr_q[IdxW-1:0]),
        .rd_data (head)
    );

    // Empty queue exposes an all-zero payload rather than stale slot contents.
    assign dq.head_uop = valid ? head : '0;
    assign dq.valid    = valid;
    assign dq.count    = count;
    assign dq.stall    = stall_q;
    assign dq.overflow = overflow_q;

`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] enq_count_q, stall_cycles_q;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enq_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (enq && (enq_count_q != '1)) begin
                enq_count_q <= enq_count_q + 32'd1;
            end
            if (stall_q && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign dq.enq_count    = enq_count_q;
    assign dq.stall_cycles = stall_cycles_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a queue-based reference model.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int unsigned Depth = 8;
    localparam int unsigned Slack = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b1;

    decode_queue_if #(.Depth(Depth)) dqif ();

    decode_queue #(
        .Depth         (Depth),
        .InFlightSlack (Slack)
    ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .dq      (dqif)
    );

    always #5 clk = ~clk;

    // Reference model state.
    uop_t        mq[$];
    bit          m_over = 1'b0;
    bit          m_stall = 1'b0;
    bit          m_deq, m_acc;
    logic [31:0] m_enq_cnt = '0;
    logic [31:0] m_stall_cyc = '0;
    logic [63:0] out_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_uop(input string name, input uop_t act, input uop_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic uop_t rand_uop(input logic [63:0] maj);
        logic [UopWidth-1:0] v;
        uop_t u;
        for (int i = 0; i < UopWidth; i++) v[i] = 1'($urandom_range(1, 0));
        u = uop_t'(v);
        u.maj_id = maj;
        return u;
    endfunction

    // Queue model: FIFO order, capacity Depth, flush empties, overflow sticky until reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_over = 1'b0;
            m_stall = 1'b0;
            m_enq_cnt = '0;
            m_stall_cyc = '0;
        end else begin
            if (m_stall && m_stall_cyc != 32'hffff_ffff) m_stall_cyc++;
            if (dqif.flush) begin
                mq.delete();
                m_stall = 1'b0;
            end else begin
                m_deq = (mq.size() != 0) && dqif.ready;
                m_acc = dqif.enable && ((mq.size() < Depth) || m_deq);
                if (dqif.enable && !m_acc) m_over = 1'b1;
                if (m_deq) void'(mq.pop_front());
                if (m_acc) begin
                    mq.push_back(dqif.enq_uop);
                    if (m_enq_cnt != 32'hffff_ffff) m_enq_cnt++;
                end
                m_stall = (mq.size() >= Depth - Slack);
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", 64'(dqif.count), 64'(mq.size()));
            chk("valid", 64'(dqif.valid), 64'(mq.size() != 0));
            chk("stall", 64'(dqif.stall), 64'(m_stall));
            chk("overflow", 64'(dqif.overflow), 64'(m_over));
            if (mq.size() != 0) chk_uop("head", dqif.head_uop, mq[0]);
`ifdef DECODE_QUEUE_PERF_EN
            chk("enq_count", 64'(dqif.enq_count), 64'(m_enq_cnt));
            chk("stall_cycles", 64'(dqif.stall_cycles), 64'(m_stall_cyc));
`endif
        end
    end

    task automatic drive(input bit en, input bit rdy, input bit fl, input logic [63:0] maj);
        dqif.enable  = en;
        dqif.ready   = rdy;
        dqif.flush   = fl;
        dqif.enq_uop = rand_uop(maj);
    endtask

    // Advance one clock; returns just after the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int sent;
    bit en;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) cycle();
        chk("rst_count", 64'(dqif.count), 64'd0);
        chk("rst_valid", 64'(dqif.valid), 64'd0);
        chk("rst_stall", 64'(dqif.stall), 64'd0);
        chk("rst_overflow", 64'(dqif.overflow), 64'd0);
        chk("rst_head_zero", 64'(dqif.head_uop == '0), 64'd1);
        rst_n = 1'b1;

        // Fill with ready low.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 64'(i));
            cycle();
            if (i == 3) chk("stall_after_4", 64'(dqif.stall), 64'd0);
            if (i == 4) chk("stall_after_5", 64'(dqif.stall), 64'd1);
        end
        chk("fill_count", 64'(dqif.count), 64'd8);
        chk("fill_head", dqif.head_uop.maj_id, 64'd0);
        chk("model_fill_size", 64'(mq.size()), 64'd8);

        // Full with simultaneous enqueue and dequeue.
        drive(1, 1, 0, 64'd8);
        cycle();
        chk("simul_count", 64'(dqif.count), 64'd8);
        chk("simul_overflow", 64'(dqif.overflow), 64'd0);
        chk("simul_head", dqif.head_uop.maj_id, 64'd1);

        // Full, enqueue without dequeue: dropped.
        drive(1, 0, 0, 64'd99);
        cycle();
        chk("ovf_flag", 64'(dqif.overflow), 64'd1);
        chk("ovf_count", 64'(dqif.count), 64'd8);
        chk("ovf_head", dqif.head_uop.maj_id, 64'd1);

        // Drain: majIDs 1..8 in order, 99 never appears.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 64'd0);
            chk("drain_order", dqif.head_uop.maj_id, 64'(i + 1));
            cycle();
        end
        chk("drain_empty", 64'(dqif.count), 64'd0);
        chk("ovf_sticky", 64'(dqif.overflow), 64'd1);

        // Flush at count 5 with enable and ready.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 64'(20 + i));
            cycle();
        end
        chk("pre_flush_count", 64'(dqif.count), 64'd5);
        drive(1, 1, 1, 64'd50);
        cycle();
        chk("flush_count", 64'(dqif.count), 64'd0);
        chk("flush_valid", 64'(dqif.valid), 64'd0);
        chk("flush_stall", 64'(dqif.stall), 64'd0);
        chk("flush_ovf_kept", 64'(dqif.overflow), 64'd1);
        drive(1, 0, 0, 64'd77);
        cycle();
        chk("post_flush_head", dqif.head_uop.maj_id, 64'd77);
        chk("post_flush_count", 64'(dqif.count), 64'd1);

        // Asynchronous reset mid-traffic, held three cycles.
        drive(1, 1, 0, 64'd78);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(dqif.valid), 64'd0);
        chk("arst_count", 64'(dqif.count), 64'd0);
        chk("arst_stall", 64'(dqif.stall), 64'd0);
        chk("arst_overflow", 64'(dqif.overflow), 64'd0);
        chk("arst_head_zero", 64'(dqif.head_uop == '0), 64'd1);
        repeat (3) begin
            drive(1'($urandom_range(1, 0)), 1, 0, 64'd0);
            cycle();
        end
        rst_n = 1'b1;

        // Wrap: 20 entries through the ring with ready toggling, decode honouring stall.
        sent = 0;
        out_log.delete();
        for (int c = 0; c < 300 && out_log.size() < 20; c++) begin
            en = (sent < 20) && !dqif.stall;
            drive(en, (c % 2) == 1, 0, 64'(sent));
            if (dqif.valid && dqif.ready) out_log.push_back(dqif.head_uop.maj_id);
            if (en) sent++;
            cycle();
        end
        chk("wrap_total", 64'(out_log.size()), 64'd20);
        foreach (out_log[i]) chk("wrap_order", out_log[i], 64'(i));

        // Randomized traffic with rare flushes and one reset pulse.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(99, 0) < 60, 1'($urandom_range(1, 0)),
                  $urandom_range(49, 0) == 0, 64'(1000 + c));
            rst_n = (c != 1500);
            cycle();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 64'd0);
        cycle();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
